pwm_capture: RTL
================

# pwm_capture

Measures an incoming PWM waveform and reports its period, high time and an 8-bit duty value on the 0–255 scale used by the PWM generator. It gives the design a closed-loop readback: generator outputs can be looped back for self-check, and external PWM sources (servo/fan tach, sensor PWM) can be decoded. It sits between an asynchronous input pin and a register/status interface. A sequential divider converts high time and period to duty without a hardware multiplier.

## Interface
- `CNT_W`, 16, width of the cycle counters and of the `period`/`high_time` outputs.
- `TIMEOUT`, 50000, cycles without an expected edge before the input is declared stuck. Must be less than 2^CNT_W.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `en`  in  1  capture enable.
- `pwm_in`  in  1  asynchronous PWM input.
- `duty`  out  8  floor(high_time*256/period); 255 when stuck high, 0 when stuck low.
- `period`  out  CNT_W  last measured period in clk cycles.
- `high_time`  out  CNT_W  last measured high time in clk cycles.
- `valid`  out  1  one-cycle pulse; `duty`/`period`/`high_time` updated this cycle.
- `stuck_hi`  out  1  input held high for ≥ TIMEOUT cycles.
- `stuck_lo`  out  1  input held low for ≥ TIMEOUT cycles.
- `overrun`  out  1  one-cycle pulse; a period shorter than 10 cycles was dropped.

## Operation
- Input path:
  - 2-flop synchronizer, then one edge-detect flop. All three reset to 0.
  - rise = s2 & ~s3; fall = ~s2 & s3.
- FSM states: IDLE, HIGH, LOW.
  - IDLE: cnt=0. On rise: cnt<=1, go to HIGH.
  - HIGH: cnt<=cnt+1. On fall: hi_lat<=cnt, go to LOW.
  - LOW: cnt<=cnt+1. On rise: per_lat<=cnt, cnt<=1, start divider, go to HIGH.
  - Result: for input high H cycles and low L cycles, hi_lat=H and per_lat=H+L.
- Divider:
  - Restoring, 8 iterations.
  - Remainder is CNT_W+1 bits, loaded with hi_lat. Each step: rem<<=1; if rem≥per_lat then subtract and shift in 1, else shift in 0.
  - hi_lat<per_lat always, so the quotient fits in 8 bits. The divider also clamps the quotient at 255.
  - The divider runs while the next period is being counted.
- Period filter: if per_lat<10, no divide is started and `overrun` pulses. All outputs hold their previous values.
- Timeout (macro-gated, see Configuration):
  - If cnt==TIMEOUT in HIGH: duty<=255, stuck_hi<=1, high_time<=period<=TIMEOUT, `valid` pulses, go to IDLE.
  - If cnt==TIMEOUT in LOW: duty<=0, stuck_lo<=1, high_time<=0, period<=TIMEOUT, `valid` pulses, go to IDLE.
  - IDLE after a stuck-high needs a fall then a rise, which happens naturally because IDLE waits for the rise.
  - Both stuck flags clear on the next divider-produced `valid`.
- Counter saturates at 2^CNT_W−1 and never wraps.
- `en` low:
  - FSM goes to IDLE, cnt is cleared and the divider is aborted with no `valid`.
  - `duty`/`period`/`high_time`/stuck flags hold their values.
  - The synchronizer keeps running.
- Simultaneous events:
  - A rise and a timeout in the same cycle: the edge wins.
  - A divider completion in the same cycle as a timeout: the timeout result wins, and the divider result is discarded.

## Timing
- Reset values: duty=0, period=0, high_time=0, valid=0, stuck_hi=0, stuck_lo=0, overrun=0, FSM=IDLE, divider idle.
- Pin to detection: an edge is detected on the 3rd clk edge after `pwm_in` changes and meets setup.
- Divide latency:
  - Detection cycle D: per_lat/hi_lat latched.
  - D+1: divider loaded.
  - D+1..D+8: iterations.
  - D+9: `duty`/`period`/`high_time` registered and `valid`=1 for exactly one cycle.
- Periods ≥10 cycles guarantee the divider is idle at the next rise, so no queueing is required.
- First `valid` after reset or `en` rise comes 9 cycles after the second detected rising edge.
- Timeout `valid` is asserted in the cycle after cnt==TIMEOUT.
- `rst` mid-divide: everything returns to reset values at once and no pending `valid` is emitted.

## Configuration
- `PWM_CAPTURE_TIMEOUT_EN` defined: timeout logic as described above.
- Not defined:
  - No timeout compare. `stuck_hi`/`stuck_lo` are tied to 0.
  - The counter saturates and the FSM waits for an edge indefinitely.
  - No `valid` is produced without edges.
  - `TIMEOUT` is ignored.

## Test plan
- 1250 high / 1250 low repeating, en=1 → after the 2nd rise: period=2500, high_time=1250, duty=128, `valid` one cycle at D+9; repeats every 2500 cycles.
- 625/1875 → duty=64; 2499/1 → duty=255; 1/2499 → duty=0, high_time=1.
- Macro on, TIMEOUT=1000, steady 50% waveform then `pwm_in` held low → cycle after cnt==1000: stuck_lo=1, duty=0, period=1000, `valid` pulse. Resume the waveform → first divider `valid` clears stuck_lo. Same check held high → stuck_hi=1, duty=255.
- 3 high / 3 low repeating → no `valid`; `overrun` pulses once per rise; outputs hold the prior 128 result.
- `rst` asserted at D+4 of a divide → all outputs 0 immediately, no `valid`. `en` dropped mid-HIGH, then raised → no `valid` until 9 cycles after the 2nd rise; prior outputs held meanwhile.
- Macro off: `pwm_in` held high for 100000 cycles → no `valid`, stuck_hi=0, cnt saturated at 65535; next fall and rise resume normal measurement.

Source files
------------

// File: rtl/pwm_capture.sv
// pwm_capture: measures an asynchronous PWM input and reports the period, the high time
// and an 8-bit duty value floor(high_time*256/period), using a sequential restoring divider.
//
// Optional feature macro: PWM_CAPTURE_TIMEOUT_EN
//   Defined     : an input stuck for TIMEOUT cycles reports duty 255/0, sets stuck_hi_o/stuck_lo_o
//                 and returns the FSM to idle.
//   Not defined : no timeout; the counter saturates and the FSM waits for the next edge.
//                 stuck_hi_o/stuck_lo_o are tied to 0 and TIMEOUT is ignored.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   en_i         capture enable; low forces idle and aborts a divide, outputs hold
//   pwm_in_i     asynchronous PWM input
//   duty_o       floor(high_time*256/period); 255 stuck high, 0 stuck low
//   period_o     last measured period in clk cycles
//   high_time_o  last measured high time in clk cycles
//   valid_o      one-cycle pulse when duty/period/high_time update
//   stuck_hi_o   input held high for TIMEOUT cycles
//   stuck_lo_o   input held low for TIMEOUT cycles
//   overrun_o    one-cycle pulse when a period shorter than 10 cycles is dropped
module pwm_capture #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             pwm_in_i,
    output logic [7:0]       duty_o,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] high_time_o,
    output logic             valid_o,
    output logic             stuck_hi_o,
    output logic             stuck_lo_o,
    output logic             overrun_o
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StHigh = 2'd1;
    localparam logic [1:0] StLow  = 2'd2;

    localparam logic [CNT_W-1:0] CntMax    = '1;
    localparam logic [CNT_W-1:0] MinPeriod = CNT_W'(10);

    // Input synchronizer and edge detect
    logic s1_q, s2_q, s3_q;
    logic rise, fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= pwm_in_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise = s2_q & ~s3_q;
    assign fall = ~s2_q & s3_q;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [CNT_W-1:0] hi_lat_q, hi_lat_d;

    logic             div_busy_q, div_busy_d;
    logic [2:0]       div_step_q, div_step_d;
    logic [CNT_W:0]   div_rem_q, div_rem_d;
    logic [7:0]       div_quo_q, div_quo_d;
    logic [CNT_W-1:0] div_per_q, div_per_d;
    logic [CNT_W-1:0] div_hi_q, div_hi_d;
    logic             div_sat_q, div_sat_d;

    logic [7:0]       duty_q, duty_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;

    // One restoring-division step
    logic [CNT_W:0]   rem_sh, rem_nx;
    logic             rem_ge;
    logic [7:0]       quo_nx;

`ifdef PWM_CAPTURE_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);
    logic stuck_hi_q, stuck_lo_q;
    logic stuck_hi_set, stuck_lo_set, div_done;
`endif

    // rem never exceeds div_per, so dropping its MSB before the shift loses nothing
    assign rem_sh  = {div_rem_q[CNT_W-1:0], 1'b0};
    assign rem_ge  = rem_sh >= {1'b0, div_per_q};
    assign rem_nx  = rem_ge ? (rem_sh - {1'b0, div_per_q}) : rem_sh;
    assign quo_nx  = {div_quo_q[6:0], rem_ge};
    assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hi_lat_d   = hi_lat_q;
        div_busy_d = div_busy_q;
        div_step_d = div_step_q;
        div_rem_d  = div_rem_q;
        div_quo_d  = div_quo_q;
        div_per_d  = div_per_q;
        div_hi_d   = div_hi_q;
        div_sat_d  = div_sat_q;
        duty_d     = duty_q;
        period_d   = period_q;
        high_d     = high_q;
        valid_d    = 1'b0;
        overrun_d  = 1'b0;
`ifdef PWM_CAPTURE_TIMEOUT_EN
        stuck_hi_set = 1'b0;
        stuck_lo_set = 1'b0;
        div_done     = 1'b0;
`endif
        if (!en_i) begin
            state_d    = StIdle;
            cnt_d      = '0;
            div_busy_d = 1'b0;
        end else begin
            if (div_busy_q) begin
                div_rem_d  = rem_nx;
                div_quo_d  = quo_nx;
                div_step_d = div_step_q + 3'd1;
                // Last iteration writes the result directly so valid lands at D+9
                if (div_step_q == 3'd7) begin
                    div_busy_d = 1'b0;
                    duty_d     = div_sat_q ? 8'hFF : quo_nx;
                    period_d   = div_per_q;
                    high_d     = div_hi_q;
                    valid_d    = 1'b1;
`ifdef PWM_CAPTURE_TIMEOUT_EN
                    div_done   = 1'b1;
`endif
                end
            end

            unique case (state_q)
                StIdle: begin
                    cnt_d = '0;
                    if (rise) begin
                        cnt_d   = CNT_W'(1);
                        state_d = StHigh;
                    end
                end
                StHigh: begin
                    cnt_d = cnt_inc;
                    if (fall) begin
                        hi_lat_d = cnt_q;
                        state_d  = StLow;
                    end
`ifdef PWM_CAPTURE_TIMEOUT_EN
                    else if (cnt_q == TimeoutVal) begin
                        // Timeout overrides any divider result finishing this cycle
                        state_d      = StIdle;
                        cnt_d        = '0;
                        div_busy_d   = 1'b0;
                        duty_d       = 8'hFF;
                        period_d     = TimeoutVal;
                        high_d       = TimeoutVal;
                        valid_d      = 1'b1;
                        div_done     = 1'b0;
                        stuck_hi_set = 1'b1;
                    end
`endif
                end
                StLow: begin
                    cnt_d = cnt_inc;
                    if (rise) begin
                        cnt_d   = CNT_W'(1);
                        state_d = StHigh;
                        if (cnt_q < MinPeriod) begin
                            overrun_d = 1'b1;
                        end else begin
                            div_busy_d = 1'b1;
                            div_step_d = 3'd0;
                            div_rem_d  = {1'b0, hi_lat_q};
                            div_quo_d  = 8'd0;
                            div_per_d  = cnt_q;
                            div_hi_d   = hi_lat_q;
                            // Only reachable when both counts saturate
                            div_sat_d  = hi_lat_q >= cnt_q;
                        end
                    end
`ifdef PWM_CAPTURE_TIMEOUT_EN
                    else if (cnt_q == TimeoutVal) begin
                        state_d      = StIdle;
                        cnt_d        = '0;
                        div_busy_d   = 1'b0;
                        duty_d       = 8'h00;
                        period_d     = TimeoutVal;
                        high_d       = '0;
                        valid_d      = 1'b1;
                        div_done     = 1'b0;
                        stuck_lo_set = 1'b1;
                    end
`endif
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            hi_lat_q   <= '0;
            div_busy_q <= 1'b0;
            div_step_q <= 3'd0;
            div_rem_q  <= '0;
            div_quo_q  <= 8'd0;
            div_per_q  <= '0;
            div_hi_q   <= '0;
            div_sat_q  <= 1'b0;
            duty_q     <= 8'd0;
            period_q   <= '0;
            high_q     <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hi_lat_q   <= hi_lat_d;
            div_busy_q <= div_busy_d;
            div_step_q <= div_step_d;
            div_rem_q  <= div_rem_d;
            div_quo_q  <= div_quo_d;
            div_per_q  <= div_per_d;
            div_hi_q   <= div_hi_d;
            div_sat_q  <= div_sat_d;
            duty_q     <= duty_d;
            period_q   <= period_d;
            high_q     <= high_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
        end
    end

`ifdef PWM_CAPTURE_TIMEOUT_EN
    // Stuck flags set on timeout and clear on the next divider-produced result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stuck_hi_q <= 1'b0;
            stuck_lo_q <= 1'b0;
        end else begin
            if (stuck_hi_set) begin
                stuck_hi_q <= 1'b1;
            end else if (div_done) begin
                stuck_hi_q <= 1'b0;
            end
            if (stuck_lo_set) begin
                stuck_lo_q <= 1'b1;
            end else if (div_done) begin
                stuck_lo_q <= 1'b0;
            end
        end
    end

    assign stuck_hi_o = stuck_hi_q;
    assign stuck_lo_o = stuck_lo_q;
`else
    assign stuck_hi_o = 1'b0;
    assign stuck_lo_o = 1'b0;
`endif

    assign duty_o      = duty_q;
    assign period_o    = period_q;
    assign high_time_o = high_q;
    assign valid_o     = valid_q;
    assign overrun_o   = overrun_q;

endmodule
